// File: rtl/shift_595_driver_if.sv
// Frame/clear handshake between a host and the 74LV595 chain driver.
interface shift_595_driver_if #(
    parameter int NCHIP = 2
) ();
    logic                 in_valid;
    logic                 in_ready;
    logic [8*NCHIP-1:0]   in_data;
    logic                 clr_req;
    logic                 done;

    modport master (
        output in_valid,
        output in_data,
        output clr_req,
        input  in_ready,
        input  done
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  clr_req,
        output in_ready,
        output done
    );
endinterface

// File: rtl/shift_595_driver.sv
// Serialises a frame MSB-first into a daisy chain of 74LV595 shift registers,
// latches it with RCLK, and can zero the chain through SRCLRn.
module shift_595_driver #(
    parameter int NCHIP  = 2,
    parameter int CLKDIV = 2
) (
    input  logic               clk,
    input  logic               rstn,
    shift_595_driver_if.slave  bus,
    input  logic               out_en,
    output logic               SER,
    output logic               SRCLK,
    output logic               RCLK,
    output logic               SRCLRn,
    output logic               OEn
);
    localparam int W  = 8 * NCHIP;
    localparam int BW = $clog2(W);
    localparam int DW = $clog2(CLKDIV + 1);

    localparam logic [BW-1:0] BIT_TOP  = BW'(W - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLKDIV - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] SH_LO  = 3'd1;
    localparam logic [2:0] SH_HI  = 3'd2;
    localparam logic [2:0] CLR_LO = 3'd3;
    localparam logic [2:0] CLR_HI = 3'd4;
    localparam logic [2:0] LT_HI  = 3'd5;
    localparam logic [2:0] LT_LO  = 3'd6;

    logic [2:0]    state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [W-1:0]  data_q, data_d;
    logic          done_q, done_d;
    logic          ser_q, ser_d;
    logic          srclk_q, srclk_d;
    logic          rclk_q, rclk_d;
    logic          srclrn_q, srclrn_d;
    logic          oen_q, oen_d;
    logic          div_last;

    assign div_last     = (div_q == DIV_LAST);
    assign bus.in_ready = (state_q == IDLE) && !bus.clr_req;
    assign bus.done     = done_q;

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        data_d  = data_q;
        done_d  = 1'b0;

        if (state_q != IDLE) begin
            div_d = div_last ? '0 : div_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (bus.clr_req) begin
                    state_d = CLR_LO;
                end else if (bus.in_valid) begin
                    state_d = SH_LO;
                    data_d  = bus.in_data;
                    bit_d   = BIT_TOP;
                end
            end
            SH_LO:  if (div_last) state_d = SH_HI;
            SH_HI: begin
                if (div_last) begin
                    if (bit_q == '0) begin
                        state_d = LT_HI;
                    end else begin
                        state_d = SH_LO;
                        bit_d   = bit_q - 1'b1;
                    end
                end
            end
            CLR_LO: if (div_last) state_d = CLR_HI;
            CLR_HI: if (div_last) state_d = LT_HI;
            LT_HI:  if (div_last) state_d = LT_LO;
            LT_LO: begin
                if (div_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Pins are registered from the next state so they line up with state_q.
        ser_d    = ((state_d == SH_LO) || (state_d == SH_HI)) ? data_d[bit_d] : 1'b0;
        srclk_d  = (state_d == SH_HI) || (state_d == CLR_HI);
        rclk_d   = (state_d == LT_HI);
        srclrn_d = !((state_d == CLR_LO) || (state_d == CLR_HI));
        oen_d    = !out_en;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= IDLE;
            div_q    <= '0;
            bit_q    <= '0;
            data_q   <= '0;
            done_q   <= 1'b0;
            ser_q    <= 1'b0;
            srclk_q  <= 1'b0;
            rclk_q   <= 1'b0;
            srclrn_q <= 1'b1;
            oen_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            data_q   <= data_d;
            done_q   <= done_d;
            ser_q    <= ser_d;
            srclk_q  <= srclk_d;
            rclk_q   <= rclk_d;
            srclrn_q <= srclrn_d;
            oen_q    <= oen_d;
        end
    end

    assign SER    = ser_q;
    assign SRCLK  = srclk_q;
    assign RCLK   = rclk_q;
    assign SRCLRn = srclrn_q;
    assign OEn    = oen_q;
endmodule

// File: tb/tb_shift_595_driver.sv
// Bench for shift_595_driver: a behavioural 595 chain on the pins plus a
// scoreboard that predicts each done pulse, its timing and the latched word.
module tb_shift_595_driver;
    localparam int NCHIP     = 2;
    localparam int CLKDIV    = 2;
    localparam int W         = 8 * NCHIP;
    localparam int FRAME_LAT = (W + 1) * 2 * CLKDIV;
    localparam int CLR_LAT   = 4 * CLKDIV;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic out_en = 1'b0;
    logic SER, SRCLK, RCLK, SRCLRn, OEn;

    shift_595_driver_if #(.NCHIP(NCHIP)) bus ();

    shift_595_driver #(.NCHIP(NCHIP), .CLKDIV(CLKDIV)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .bus    (bus),
        .out_en (out_en),
        .SER    (SER),
        .SRCLK  (SRCLK),
        .RCLK   (RCLK),
        .SRCLRn (SRCLRn),
        .OEn    (OEn)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cycleCnt = 0;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // Behavioural 595 chain: shift on SRCLK rise, async clear, latch on RCLK rise.
    logic [W-1:0] chainSr = '0;
    logic [W-1:0] storage = '0;
    logic [W-1:0] qModel;
    int srEdgeCnt = 0;
    int rclkCnt = 0;

    always @(posedge SRCLK or negedge SRCLRn) begin
        if (!SRCLRn) chainSr <= '0;
        else chainSr <= {chainSr[W-2:0], SER};
        if (SRCLK) srEdgeCnt <= srEdgeCnt + 1;
    end

    always @(posedge RCLK) begin
        storage <= chainSr;
        rclkCnt <= rclkCnt + 1;
    end

    assign qModel = OEn ? '0 : storage;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    typedef struct {
        logic [W-1:0] data;
        int           doneCycle;
        int           srBase;
        int           rclkBase;
        int           srExpected;
    } expItem_t;

    expItem_t sbQueue[$];
    int  busyUntil = -1;
    bit  resetApplied = 0;
    bit  oenValid = 0;
    logic oenExp = 1'b1;

    // Monitor/scoreboard: runs on the falling edge, independent of the stimulus.
    always @(negedge clk) begin
        expItem_t it;
        if (resetApplied) begin
            checkOutput("rstSER", 32'(SER), 32'd0);
            checkOutput("rstSRCLK", 32'(SRCLK), 32'd0);
            checkOutput("rstRCLK", 32'(RCLK), 32'd0);
            checkOutput("rstSRCLRn", 32'(SRCLRn), 32'd1);
            checkOutput("rstDone", 32'(bus.done), 32'd0);
            resetApplied = 0;
        end
        if (oenValid) checkOutput("OEn", 32'(OEn), 32'(oenExp));
        if (cycleCnt > 0)
            checkOutput("in_ready", 32'(bus.in_ready), 32'((cycleCnt > busyUntil) && !bus.clr_req));

        if (bus.done) begin
            if (sbQueue.size() == 0) begin
                checkOutput("unexpectedDone", 32'd1, 32'd0);
            end else begin
                it = sbQueue.pop_front();
                checkOutput("doneCycle", 32'(cycleCnt), 32'(it.doneCycle));
                checkOutput("latched", 32'(storage), 32'(it.data));
                checkOutput("srclkEdges", 32'(srEdgeCnt - it.srBase), 32'(it.srExpected));
                checkOutput("rclkEdges", 32'(rclkCnt - it.rclkBase), 32'd1);
            end
        end else if (sbQueue.size() > 0 && cycleCnt > sbQueue[0].doneCycle) begin
            checkOutput("doneTimeout", 32'd0, 32'd1);
            void'(sbQueue.pop_front());
        end

        if (!rstn) begin
            sbQueue.delete();
            busyUntil = -1;
            resetApplied = 1;
        end else if (cycleCnt > busyUntil) begin
            if (bus.clr_req) begin
                it.data = '0;
                it.doneCycle = cycleCnt + 1 + CLR_LAT;
                it.srExpected = 1;
                it.srBase = srEdgeCnt;
                it.rclkBase = rclkCnt;
                sbQueue.push_back(it);
                busyUntil = cycleCnt + CLR_LAT;
            end else if (bus.in_valid) begin
                it.data = bus.in_data;
                it.doneCycle = cycleCnt + 1 + FRAME_LAT;
                it.srExpected = W;
                it.srBase = srEdgeCnt;
                it.rclkBase = rclkCnt;
                sbQueue.push_back(it);
                busyUntil = cycleCnt + FRAME_LAT;
            end
        end
        oenExp = rstn ? !out_en : 1'b1;
        oenValid = 1;
    end

    task automatic applyStimulus(input logic v, input logic [W-1:0] d, input logic c);
        @(posedge clk);
        #1;
        bus.in_valid = v;
        bus.in_data  = d;
        bus.clr_req  = c;
    endtask

    task automatic waitReady();
        bit got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (bus.in_ready) got = 1;
        end
        if (!got) checkOutput("readyTimeout", 32'd0, 32'd1);
    endtask

    task automatic waitDone();
        bit got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (bus.done) got = 1;
        end
        if (!got) checkOutput("waitDoneTimeout", 32'd0, 32'd1);
    endtask

    task automatic sendFrame(input logic [W-1:0] d);
        applyStimulus(1'b1, d, 1'b0);
        waitReady();
        applyStimulus(1'b0, '0, 1'b0);
    endtask

    initial begin
        logic [W-1:0] rd;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.clr_req  = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        out_en = 1'b1;

        sendFrame(16'hA55A);
        waitDone();
        @(negedge clk);
        checkOutput("frameChip1", 32'(qModel[15:8]), 32'h0A5);
        checkOutput("frameChip0", 32'(qModel[7:0]), 32'h05A);

        // Back-to-back: second accept must land in the done cycle of the first.
        applyStimulus(1'b1, 16'h1234, 1'b0);
        waitReady();
        @(posedge clk);
        #1;
        bus.in_data = 16'hFFFF;
        waitReady();
        checkOutput("b2bAcceptInDone", 32'(bus.done), 32'd1);
        applyStimulus(1'b0, '0, 1'b0);
        waitDone();
        @(negedge clk);
        checkOutput("b2bQ", 32'(qModel), 32'hFFFF);

        sendFrame(16'hA55A);
        waitDone();
        applyStimulus(1'b1, 16'hBEEF, 1'b1);
        applyStimulus(1'b0, '0, 1'b0);
        waitDone();
        @(negedge clk);
        checkOutput("clearQ", 32'(qModel), 32'h0);

        // Abort a 0x00FF frame with reset while bit 5 is on SER.
        sendFrame(16'hA55A);
        waitDone();
        sendFrame(16'h00FF);
        repeat (40) @(posedge clk);
        #1;
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("abortLatched", 32'(storage), 32'hA55A);
        checkOutput("abortQ", 32'(qModel), 32'hA55A);

        @(posedge clk);
        #1;
        out_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("oeOffOEn", 32'(OEn), 32'd1);
        checkOutput("oeOffQ", 32'(qModel), 32'h0);
        @(posedge clk);
        #1;
        out_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("oeOnQ", 32'(qModel), 32'hA55A);

        for (int i = 0; i < 400; i++) begin
            rd = W'($urandom);
            applyStimulus(1'($urandom_range(0, 1)), rd, ($urandom_range(0, 19) == 0));
            if ($urandom_range(0, 9) == 0) out_en = ~out_en;
        end
        applyStimulus(1'b0, '0, 1'b0);
        repeat (FRAME_LAT + 10) @(posedge clk);
        @(negedge clk);
        checkOutput("queueDrained", 32'(sbQueue.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/shift_595_driver.md
SHIFT_595_DRIVER -- requirements
Module: shift_595_driver

Interface
REQ-001 SHALL have parameter NCHIP, default 2, the number of daisy-chained 74LV595 devices driven (≥1).
REQ-002 SHALL have parameter CLKDIV, default 2, the clk cycles per half-period of SRCLK and RCLK (≥1).
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port rstn  input  1  reset; synchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  frame request.
REQ-006 SHALL have port in_ready  output  1  driver can accept a frame this cycle.
REQ-007 SHALL have port in_data  input  8*NCHIP  frame; in_data[7:0] targets the chip fed directly by SER.
REQ-008 SHALL have port clr_req  input  1  request to zero all chip outputs.
REQ-009 SHALL have port out_en  input  1  enable chip parallel outputs.
REQ-010 SHALL have port done  output  1  one-cycle pulse at the end of a frame or clear sequence.
REQ-011 SHALL have port SER, SRCLK, RCLK, SRCLRn, OEn  output  1 each  registered pins to the first chip.

Function
REQ-012 SHALL implement states IDLE, SH_LO, SH_HI, CLR_LO, CLR_HI, LT_HI, LT_LO, each held for exactly CLKDIV cycles, except IDLE.
REQ-013 in_ready SHALL equal (state==IDLE && !clr_req); accept = in_valid && in_ready; in_data is captured on the accept edge and later changes are ignored.
REQ-014 In IDLE, clr_req=1 SHALL take priority: next state CLR_LO; otherwise accept leads to SH_LO; otherwise stay in IDLE.
REQ-015 Shifting SHALL be MSB-first: bit i = 8*NCHIP-1 down to 0, one bit per SH_LO/SH_HI pair; SER holds the current bit throughout the pair.
REQ-016 SRCLK SHALL be 0 in SH_LO and 1 in SH_HI. SRCLK rises only at an SH_LO->SH_HI transition, so SER is stable ≥CLKDIV cycles before and after each rising edge.
REQ-017 After SH_HI of bit 0 the state SHALL go to LT_HI; otherwise it SHALL go to SH_LO with the bit counter decremented.
REQ-018 CLR_LO/CLR_HI SHALL drive SRCLRn=0, with SRCLK 0 then 1 (one clearing edge). The state SHALL then go to LT_HI with SRCLRn back to 1.
REQ-019 RCLK SHALL be 1 in LT_HI and 0 elsewhere; LT_HI->LT_LO->IDLE.
REQ-020 done SHALL be 1 for exactly the first IDLE cycle after LT_LO; in_ready may be high in that same cycle.
REQ-021 Frame latency: done SHALL assert (8*NCHIP+1)*2*CLKDIV cycles after the accept edge (68 at defaults).
REQ-022 Clear latency: done SHALL assert 4*CLKDIV cycles after the edge that leaves IDLE for CLR_LO.
REQ-023 SER SHALL be 0 outside SH_LO/SH_HI.
REQ-024 SRCLRn SHALL be 1 outside CLR_LO/CLR_HI.
REQ-025 OEn SHALL be the registered value of !out_en (1-cycle latency), independent of state; out_en changes mid-frame are legal.
REQ-026 clr_req and in_valid SHALL be ignored outside IDLE; no queuing.
REQ-027 The bit counter SHALL be ceil(log2(8*NCHIP)) bits and the divider counter ceil(log2(CLKDIV+1)) bits; neither SHALL wrap during a sequence.

Reset
REQ-028 While rstn=0 at a clk edge: state=IDLE, SER=0, SRCLK=0, RCLK=0, SRCLRn=1, OEn=1, done=0, and all counters=0.
REQ-029 Reset mid-sequence SHALL abort the sequence without an RCLK edge, so chip outputs keep their previous frame. in_ready SHALL be 1 on the first cycle after rstn returns to 1, provided clr_req=0.

Verification
REQ-030 Reset: hold rstn=0 for 3 cycles -> SER/SRCLK/RCLK=0, SRCLRn=1, OEn=1, in_ready=1 (clr_req=0), done=0.
REQ-031 Frame: defaults, two-chip 595 model, out_en=1, send 0xA55A -> exactly 16 SRCLK and 1 RCLK rising edges; done 68 cycles after accept; chip1 Q=0xA5, chip0 Q=0x5A.
REQ-032 Back-to-back: in_valid held high with 0x1234 then 0xFFFF -> second accept in the done cycle of the first; final Q=0xFF/0xFF; in_ready=0 throughout each frame.
REQ-033 Clear: after 0xA55A, clr_req=1 for one IDLE cycle with in_valid=1 -> in_valid not accepted; done 8 cycles after leaving IDLE; both chips Q=0x00.
REQ-034 Abort: send 0x00FF after 0xA55A, assert rstn=0 during bit 5 -> pins reset next edge; no RCLK edge; Q remains 0xA5/0x5A.
REQ-035 Output enable: out_en=0 after a frame -> OEn=1 one cycle later and model Q reads 0x00. out_en=1 -> Q restored to the latched value.
